// File: rtl/chan_seq_if.sv
// Start/fault request and channel-enable status bundle between the startup-delay
// stage (master) and the channel sequencer (slave).
interface chan_seq_if #(
    parameter int CH_NUM = 4
);
    logic              i_start;
    logic              i_fault;
    logic [CH_NUM-1:0] o_ch_en;
    logic              o_busy;
    logic              o_done;
    logic              o_fault;

    modport master (
        output i_start, i_fault,
        input  o_ch_en, o_busy, o_done, o_fault
    );

    modport slave (
        input  i_start, i_fault,
        output o_ch_en, o_busy, o_done, o_fault
    );
endinterface

// File: rtl/chan_seq.sv
// Power-on channel sequencer: enables CH_NUM channels one per STEP_CYCLES after start.
// Define CHAN_SEQ_FAULT_EN to build the fault synchronizer and the sticky FAULT state.
module chan_seq #(
    parameter int CH_NUM      = 4,
    parameter int STEP_CYCLES = 50000000
) (
    input  logic      i_clk_50M,
    input  logic      i_rst_n,
    chan_seq_if.slave bus
);

    localparam int                CNT_W    = $clog2(STEP_CYCLES);
    localparam int                IDX_W    = $clog2(CH_NUM + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(CH_NUM - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [CH_NUM-1:0] CH_FIRST = CH_NUM'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [CH_NUM-1:0] r_ch_en;
    logic [CH_NUM-1:0] w_ch_en_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_fault_req;

`ifdef CHAN_SEQ_FAULT_EN
    logic r_fault_meta;
    logic r_fault_sync;
    logic r_fault;

    // Two-flop synchronizer for the asynchronous fault request; r_fault is the sticky flag.
    always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fault_meta <= 1'b0;
            r_fault_sync <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_fault_meta <= bus.i_fault;
            r_fault_sync <= r_fault_meta;
            if (r_fault_sync) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign w_fault_req = r_fault_sync;
    assign bus.o_fault = r_fault;
`else
    logic w_unused_fault;

    assign w_unused_fault = bus.i_fault;
    assign w_fault_req    = 1'b0;
    assign bus.o_fault    = 1'b0;
`endif

    always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ch_en <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ch_en <= w_ch_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_ch_en_nxt = r_ch_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;

        unique case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_ch_en_nxt = CH_FIRST;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = IDX_ONE;
                    if (CH_NUM == 1) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                // Terminal count: enable the next channel and restart the spacing interval.
                if (r_cnt == CNT_LAST) begin
                    w_ch_en_nxt = r_ch_en | (CH_FIRST << r_idx);
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + IDX_ONE;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            DONE, FAULT: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Fault outranks both the start request and a coincident step event.
        if (w_fault_req) begin
            w_state_nxt = FAULT;
            w_cnt_nxt   = '0;
            w_ch_en_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    assign bus.o_ch_en = r_ch_en;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;

endmodule

// File: tb/tb_chan_seq.sv
// Self-checking bench for chan_seq (CH_NUM=4, STEP_CYCLES=10) against a cycle-index model.
module tb_chan_seq;

    localparam int CH   = 4;
    localparam int STEP = 10;
`ifdef CHAN_SEQ_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    chan_seq_if #(.CH_NUM(CH)) bus ();

    chan_seq #(
        .CH_NUM      (CH),
        .STEP_CYCLES (STEP)
    ) dut (
        .i_clk_50M (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    logic [6:0] obs;
    assign obs = {bus.o_ch_en, bus.o_busy, bus.o_done, bus.o_fault};

    // Expected {ch_en, busy, done, fault} after edge E0+k; fault first sampled at edge E0+f.
    function automatic logic [6:0] exp_out(input int k, input bit has_f, input int f);
        int         n;
        logic [3:0] mask;
        if (FAULT_EN && has_f && k >= f + 2) return 7'b0000_001;
        if (k < 0) return 7'b0;
        n = k / STEP + 1;
        if (n > CH) n = CH;
        mask = 4'((1 << n) - 1);
        return {mask, (n < CH), (n == CH), 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.i_start = 1'b0;
        bus.i_fault = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_fault = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #3;
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL reset_async got=%b exp=%b", obs, 7'b0);
        end
        repeat (3) tick();
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL reset_held got=%b exp=%b", obs, 7'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (obs !== 7'b0) begin
                bad++;
                $display("FAIL idle_no_start k=%0d got=%b exp=%b", k, obs, 7'b0);
            end
        end
    endtask

    task automatic test_basic_sequence();
        logic [6:0] e;
        apply_reset();
        for (int k = -3; k < 36; k++) begin
            bus.i_start = (k >= 0);
            tick();
            e = exp_out(k, 1'b0, 0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL basic_seq k=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_start_drop();
        logic [6:0] e;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            bus.i_start = (k < 6);
            tick();
            e = exp_out(k, 1'b0, 0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL start_drop k=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] e;
        apply_reset();
        bus.i_start = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            tick();
            e = exp_out(k, 1'b0, 0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL mid_reset_pre k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        rst_n = 1'b0;
        #2;
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL mid_reset_async got=%b exp=%b", obs, 7'b0);
        end
        repeat (2) tick();
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL mid_reset_held got=%b exp=%b", obs, 7'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 35; k++) begin
            tick();
            e = exp_out(k, 1'b0, 0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL mid_reset_restart k=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

`ifdef CHAN_SEQ_FAULT_EN
    task automatic test_fault();
        logic [6:0] e;
        apply_reset();
        for (int k = 0; k < 114; k++) begin
            bus.i_start = 1'b1;
            bus.i_fault = (k == 12);
            tick();
            e = exp_out(k, 1'b1, 12);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL fault_mid_seq k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        bus.i_fault = 1'b0;
    endtask

    task automatic test_fault_before_start();
        logic [6:0] e;
        apply_reset();
        for (int k = -6; k < 26; k++) begin
            bus.i_start = (k >= 0);
            bus.i_fault = (k == -5);
            tick();
            e = exp_out(k, 1'b1, -5);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL fault_before_start k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        bus.i_fault = 1'b0;
    endtask
`else
    task automatic test_fault_ignored();
        logic [6:0] e;
        apply_reset();
        for (int k = 0; k < 41; k++) begin
            bus.i_start = 1'b1;
            bus.i_fault = 1'($urandom_range(0, 1));
            tick();
            e = exp_out(k, 1'b1, 0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL fault_ignored k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        bus.i_fault = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [6:0] e;
        int         idle;
        int         drop;
        int         f;
        bit         has_f;
        for (int it = 0; it < 8; it++) begin
            idle  = int'($urandom_range(0, 5));
            drop  = int'($urandom_range(1, 40));
            has_f = 1'($urandom_range(0, 1));
            f     = int'($urandom_range(0, 40)) - idle;
            apply_reset();
            for (int k = -idle; k < 46; k++) begin
                bus.i_start = (k >= 0 && k < drop);
                bus.i_fault = has_f && (k == f);
                tick();
                e = exp_out(k, has_f, f);
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL random it=%0d k=%0d f=%0d got=%b exp=%b", it, k, f, obs, e);
                end
            end
            bus.i_fault = 1'b0;
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_fault = 1'b0;
        test_reset();
        test_basic_sequence();
        test_start_drop();
        test_mid_reset();
`ifdef CHAN_SEQ_FAULT_EN
        test_fault();
        test_fault_before_start();
`else
        test_fault_ignored();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chan_seq.md
# chan_seq

Power-on channel sequencer downstream of the startup-delay stage. When the startup delay's start flag goes high, the block switches on the box's output channels one at a time, with a fixed spacing between them, so the supply never sees all loads at once. It reports sequencing progress and completion. An optional fault input forces every channel off and latches the block until reset.

## Interface
- CH_NUM, 4: number of output channels; legal range 1..16.
- STEP_CYCLES, 50000000: spacing between successive channel enables, in i_clk_50M cycles (1 s at 50 MHz); minimum 2.
- i_clk_50M  in  1  50 MHz system clock; all logic on its rising edge.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_start  in  1  start flag from the startup-delay stage; same clock domain, sticky high once asserted.
- i_fault  in  1  external fault request, asynchronous, active-high.
- o_ch_en  out  CH_NUM  per-channel enable; bit 0 switches on first.
- o_busy  out  1  high while sequencing is in progress.
- o_done  out  1  high once all channels are enabled.
- o_fault  out  1  high once a fault has been latched.

## Operation
- States: IDLE, RUN, DONE, FAULT; state register is binary-encoded.
- Reset: state=IDLE, step counter=0, channel index=0; o_ch_en=0, o_busy=0, o_done=0, o_fault=0.
- IDLE: while i_start=0, outputs stay in their reset values.
  - At the first edge E0 that samples i_start=1: o_ch_en=1 (bit 0), counter=0, index=1.
  - If CH_NUM=1, the state goes straight to DONE at E0.
  - Otherwise the state goes to RUN and o_busy=1.
- RUN: the counter increments every cycle.
  - When counter reaches STEP_CYCLES-1: set bit[index] of o_ch_en, clear the counter, increment the index.
  - Enabled bits are never cleared in RUN.
  - On the edge that sets bit CH_NUM-1: state goes to DONE, o_busy=0, o_done=1.
- DONE: outputs hold. The counter is frozen at 0. i_start is ignored.
- i_start falling after E0 is ignored; the sequence continues.
- Counter width is $clog2(STEP_CYCLES). The counter never wraps: it is cleared exactly at the terminal count.
- Reset asserted in any state (mid-sequence included) returns all outputs to reset values immediately, without waiting for a clock edge.
- After reset release, a still-high i_start restarts the sequence from channel 0.

## Timing
- Channel k (0-based) rises on edge E0 + k*STEP_CYCLES.
- Sequence length from E0 to o_done rising is (CH_NUM-1)*STEP_CYCLES cycles.
- Start-to-first-enable latency is 1 cycle, because o_ch_en is registered on E0.
- All outputs are registered, with no combinational paths from inputs to outputs.
- i_fault passes through a 2-flop synchronizer before use.
  - If a pulse on i_fault is sampled high by the first synchronizer flop at edge F, the FSM sees it at F+1.
  - At F+2: o_ch_en=0, o_busy=0, o_done=0, o_fault=1.
- Fault has priority over start and over the step event when both fall on the same edge.

## Configuration
- CHAN_SEQ_FAULT_EN defined:
  - The synchronizer and the FAULT state are built.
  - FAULT is entered from any state and is sticky until reset.
  - In FAULT, i_start is ignored.
- CHAN_SEQ_FAULT_EN undefined:
  - The i_fault port remains but is unused.
  - No synchronizer is built and FAULT is unreachable.
  - o_fault is tied to 0.

## Test plan
Benches use CH_NUM=4 and STEP_CYCLES=10, with CHAN_SEQ_FAULT_EN defined unless stated otherwise.
- Basic sequence: release reset, assert i_start at edge E0.
  - o_ch_en reads 0001@E0, 0011@E0+10, 0111@E0+20, 1111@E0+30.
  - o_done=1 and o_busy=0 from E0+30; o_busy=1 over the interval E0..E0+29.
- Start drop: deassert i_start at E0+5. The sequence completes unchanged, with 1111 at E0+30.
- Mid-sequence reset: pull i_rst_n low at E0+15.
  - All outputs go to 0 immediately, without a clock edge.
  - Release reset with i_start held high: the sequence restarts and 0001 appears on the first edge after release.
- Fault: pulse i_fault for 1 cycle so it is sampled at E0+12.
  - At E0+14: o_ch_en=0000 and o_fault=1.
  - All outputs then hold for 100 cycles with i_start=1.
- Fault before start: assert i_fault in IDLE, then assert i_start. o_ch_en stays 0 and o_fault=1.
- Macro off: rebuild without CHAN_SEQ_FAULT_EN, then toggle i_fault during the sequence. Timing matches the basic-sequence case and o_fault stays 0.
